// File: rtl/counter_sweep_ctrl.sv
// Sequencer for an external up/down counter: clears it, then sweeps its count
// as a triangle wave between latched lo/hi limits, optionally dwelling at each
// endpoint, for a fixed number of sweeps or until stopped.
module counter_sweep_ctrl #(
  parameter int W  = 4,
  parameter int DW = 8,
  parameter int NW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [W-1:0]  lo_lim,
  input  logic [W-1:0]  hi_lim,
  input  logic [DW-1:0] dwell,
  input  logic [NW-1:0] n_sweeps,
  input  logic [W-1:0]  cnt_val,
  output logic          cnt_rst,
  output logic          cnt_en,
  output logic          cnt_dir,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [NW-1:0] sweep_cnt
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, PRELOAD, UP, DWELL_HI, DOWN, DWELL_LO
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [NW-1:0] n_q, n_d;
  logic [DW-1:0] timer_q, timer_d;
  logic [NW-1:0] sweep_q, sweep_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [NW-1:0] sweep_inc;
  logic [W-1:0]  target;
  logic          stop_run;

  assign sweep_inc = sweep_q + 1'b1;
  assign target    = (state_q == UP) ? hi_q : lo_q;
  // A stop only matters while a run is in progress.
  assign stop_run  = stop && (state_q != IDLE);

  // State and configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      dwell_q <= '0;
      n_q     <= '0;
      timer_q <= '0;
      sweep_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      dwell_q <= dwell_d;
      n_q     <= n_d;
      timer_q <= timer_d;
      sweep_q <= sweep_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: command handling, endpoint detection, dwell timing.
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    dwell_d = dwell_q;
    n_d     = n_q;
    timer_d = timer_q;
    sweep_d = sweep_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (lo_lim < hi_lim) begin
            lo_d    = lo_lim;
            hi_d    = hi_lim;
            dwell_d = dwell;
            n_d     = n_sweeps;
            sweep_d = '0;
            state_d = CLEAR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CLEAR: state_d = PRELOAD;
      PRELOAD: begin
        if (cnt_val == lo_q) state_d = UP;
      end
      UP: begin
        if (cnt_val == hi_q) begin
          if (dwell_q != '0) begin
            timer_d = dwell_q - 1'b1;
            state_d = DWELL_HI;
          end else begin
            state_d = DOWN;
          end
        end
      end
      DWELL_HI: begin
        if (timer_q == '0) state_d = DOWN;
        else               timer_d = timer_q - 1'b1;
      end
      DOWN: begin
        if (cnt_val == lo_q) begin
          sweep_d = sweep_inc;
          if ((n_q != '0) && (sweep_inc == n_q)) begin
            // Final sweep: no trailing dwell.
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (dwell_q != '0) begin
            timer_d = dwell_q - 1'b1;
            state_d = DWELL_LO;
          end else begin
            state_d = UP;
          end
        end
      end
      DWELL_LO: begin
        if (timer_q == '0) state_d = UP;
        else               timer_d = timer_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides every transition; the sweep count is kept as-is.
    if (stop_run) begin
      state_d = IDLE;
      timer_d = timer_q;
      sweep_d = sweep_q;
      done_d  = 1'b0;
    end
  end

  // Counter drive: enable stops exactly on target and is cut by a stop request
  // in the same cycle so the count is left where it was.
  always_comb begin
    cnt_rst = (state_q == CLEAR);
    cnt_en  = 1'b0;
    cnt_dir = 1'b0;
    case (state_q)
      PRELOAD, UP: begin
        cnt_dir = 1'b1;
        cnt_en  = (cnt_val != target) && !stop;
      end
      DOWN: begin
        cnt_dir = 1'b0;
        cnt_en  = (cnt_val != target) && !stop;
      end
      default: begin
        cnt_dir = 1'b0;
        cnt_en  = 1'b0;
      end
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign sweep_cnt = sweep_q;

endmodule
